// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic datapath blocks (SNG, multiplier, decoder).
package stoch_pkg;

    localparam int STOCH_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stoch_window_counter.sv
// Window counter: counts accepted samples and ones over a 2^WIDTH-sample window.
module stoch_window_counter
    import stoch_pkg::*;
#(
    parameter int WIDTH = STOCH_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_ones_cnt,
    output logic             o_last_sample
);

    logic [WIDTH-1:0] r_sample_cnt;
    logic [WIDTH:0]   r_ones_cnt;

    // sample_cnt wraps to zero on the final sample of the window
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (i_clear) begin
            r_sample_cnt <= '0;
            r_ones_cnt   <= '0;
        end else if (i_en) begin
            r_sample_cnt <= r_sample_cnt + WIDTH'(1);
            r_ones_cnt   <= r_ones_cnt + {{WIDTH{1'b0}}, i_bit};
        end
    end

    assign o_ones_cnt    = r_ones_cnt;
    assign o_last_sample = &r_sample_cnt;

endmodule

// File: rtl/stoch_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WIDTH valid samples, result on valid/ready.
// Define STOCH_DEC_BIPOLAR_EN for bipolar (offset two's-complement) decode; default is unipolar.
module stoch_bitstream_decoder
    import stoch_pkg::*;
#(
    parameter int WIDTH = STOCH_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_value,
    output logic             o_value_valid,
    input  logic             i_value_ready
);

    state_t           r_state;
    logic             r_busy;
    logic             r_value_valid;
    logic [WIDTH-1:0] r_value;

    logic             w_start_ok;
    logic             w_sample;
    logic             w_last_sample;
    logic [WIDTH:0]   w_ones_cnt;
    logic [WIDTH:0]   w_final;
    logic [WIDTH-1:0] w_result;

    assign w_start_ok = i_start && ((r_state == IDLE) || ((r_state == DONE) && i_value_ready));
    assign w_sample   = (r_state == ACCUM) && i_bit_valid;

    stoch_window_counter #(
        .WIDTH (WIDTH)
    ) u_window_counter (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (w_start_ok),
        .i_en          (w_sample),
        .i_bit         (i_bit_in),
        .o_ones_cnt    (w_ones_cnt),
        .o_last_sample (w_last_sample)
    );

    // The final sample is folded in here so the result registers on the same edge
    assign w_final = w_ones_cnt + {{WIDTH{1'b0}}, i_bit_in};

`ifdef STOCH_DEC_BIPOLAR_EN
    assign w_result = w_final[WIDTH] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {~w_final[WIDTH-1], w_final[WIDTH-2:0]};
`else
    assign w_result = w_final[WIDTH] ? {WIDTH{1'b1}} : w_final[WIDTH-1:0];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_value_valid <= 1'b0;
            r_value       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= ACCUM;
                        r_busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (i_bit_valid && w_last_sample) begin
                        r_state       <= DONE;
                        r_busy        <= 1'b0;
                        r_value_valid <= 1'b1;
                        r_value       <= w_result;
                    end
                end
                DONE: begin
                    if (i_value_ready) begin
                        r_value_valid <= 1'b0;
                        if (i_start) begin
                            r_state <= ACCUM;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                    r_value_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;

endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// Scoreboard bench: driver pushes expected result and arrival cycle; negedge monitor pops and compares.
module tb_stoch_bitstream_decoder;

    localparam int W = 8;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start, i_bit_in, i_bit_valid, i_value_ready;
    logic         o_busy, o_value_valid;
    logic [W-1:0] o_value;

    stoch_bitstream_decoder #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (i_start),
        .i_bit_in      (i_bit_in),
        .i_bit_valid   (i_bit_valid),
        .o_busy        (o_busy),
        .o_value       (o_value),
        .o_value_valid (o_value_valid),
        .i_value_ready (i_value_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int cyc; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   smp [N];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference decode from the count of ones in the window
    function automatic int model(input int n);
`ifdef STOCH_DEC_BIPOLAR_EN
        int d;
        d = n - N/2;
        if (d > N/2 - 1) d = N/2 - 1;
        if (d < -(N/2)) d = -(N/2);
        return d & (N - 1);
`else
        return (n > N - 1) ? N - 1 : n;
`endif
    endfunction

    // Monitor
    logic         prev_vld = 1'b0;
    logic [W-1:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (o_value_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("value", int'(o_value), e.val);
                    check("latency_cycle", cyc, e.cyc);
                end
                held = o_value;
            end else if (o_value_valid) begin
                check("value_stable", int'(o_value), int'(held));
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                check("result_timeout", 0, 1);
                void'(sb.pop_front());
            end
            prev_vld = o_value_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_prefix(input int k);
        for (int i = 0; i < N; i++) smp[i] = (i < k);
    endtask

    task automatic fill_random();
        int p;
        p = $urandom_range(0, 4);
        for (int i = 0; i < N; i++) smp[i] = ($urandom_range(0, 3) < p);
    endtask

    // Start cycle: the sample presented here must not be counted
    task automatic begin_window();
        i_start = 1'b1; i_value_ready = 1'b1; i_bit_valid = 1'b1; i_bit_in = 1'b1;
        tick();
        check("busy_after_start", int'(o_busy), 1);
    endtask

    // mode 0: continuous valid, 1: toggling valid, 2: random stalls
    task automatic feed(input int mode);
        int  idx, ones, last;
        bit  ph;
        bit  v;
        idx = 0; ones = 0; last = cyc; ph = 1'b1;
        for (int i = 0; i < N; i++) ones += smp[i];
        while (idx < N) begin
            i_start       = 1'($urandom_range(0, 1));
            i_value_ready = 1'($urandom_range(0, 1));
            case (mode)
                0:       v = 1'b1;
                1:       begin v = ph; ph = ~ph; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_bit_valid = v;
            if (v) begin
                i_bit_in = smp[idx];
                idx++;
                last = cyc;
            end else begin
                i_bit_in = 1'($urandom_range(0, 1));
            end
            tick();
        end
        i_start = 1'b0; i_value_ready = 1'b0;
        i_bit_valid = 1'($urandom_range(0, 1)); i_bit_in = 1'($urandom_range(0, 1));
        sb.push_back('{model(ones), last + 1});
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            i_start = 1'($urandom_range(0, 1));
            i_value_ready = 1'b0;
            tick();
        end
    endtask

    task automatic release_idle();
        i_value_ready = 1'b1; i_start = 1'b0;
        tick();
        i_value_ready = 1'b0;
        check("valid_low_after_ack", int'(o_value_valid), 0);
        check("idle_after_ack", int'(o_busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_bit_in = 1'b0; i_bit_valid = 1'b0; i_value_ready = 1'b0;
        repeat (3) tick();
        check("reset_busy", int'(o_busy), 0);
        check("reset_valid", int'(o_value_valid), 0);
        check("reset_value", int'(o_value), 0);
        rst = 1'b0;
        tick();

        fill_prefix(N); begin_window(); feed(0); hold(2); release_idle();

        // Asynchronous reset mid-window, after 100 samples
        begin_window();
        repeat (100) begin
            i_start = 1'b0; i_bit_valid = 1'b1; i_bit_in = 1'b1;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", int'(o_busy), 0);
        check("midreset_valid", int'(o_value_valid), 0);
        check("midreset_value", int'(o_value), 0);
        tick();
        rst = 1'b0;
        tick();

        fill_prefix(N);  begin_window(); feed(0); release_idle();
        fill_prefix(64); begin_window(); feed(0); release_idle();
        fill_prefix(0);  begin_window(); feed(0); release_idle();

        // Toggling valid, 128 ones, then 20 cycles of backpressure with start pulses
        for (int i = 0; i < N; i++) smp[i] = i[0];
        begin_window(); feed(1); hold(20);
        check("held_valid", int'(o_value_valid), 1);
        check("held_not_busy", int'(o_busy), 0);
        release_idle();

        // Back-to-back: start and ready together in DONE
        fill_prefix(N);  begin_window(); feed(0); hold(3);
        fill_prefix(32); begin_window(); feed(0); release_idle();

        for (int r = 0; r < 6; r++) begin
            fill_random(); begin_window(); feed(2); hold($urandom_range(0, 4));
            if (r[0]) release_idle();
        end

        repeat (4) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stoch_bitstream_decoder.md
Name: stoch_bitstream_decoder

Overview:
- Stochastic-to-binary converter: the reverse direction of the stochastic adder/multiplier datapath.
- Counts ones in a unipolar stochastic bitstream over a fixed window of 2^WIDTH valid samples.
- Returns the binary-encoded probability through a valid/ready result port.
- Sits after the multiplier output so products can be read back as binary words.

Parameters:
- WIDTH, 8, output word width; window length = 2^WIDTH valid samples (min 2).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new decode window; accepted only in IDLE or in DONE-with-handshake
- bit_in  input  1  stochastic bitstream sample
- bit_valid  input  1  bit_in is a valid sample this cycle
- busy  output  1  high while in ACCUM
- value  output  WIDTH  decoded result; stable while value_valid is high
- value_valid  output  1  result available
- value_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, value=0, value_valid=0; internal counters cleared. Reset mid-window discards the partial count.
- States:
  - IDLE: start=1 -> ACCUM, clear sample_cnt (WIDTH bits) and ones_cnt (WIDTH+1 bits).
  - ACCUM: each cycle with bit_valid=1 -> sample_cnt+1; ones_cnt+1 if bit_in=1. bit_valid=0 stalls both counters, with no timeout. start is ignored. When a valid sample is accepted with sample_cnt == 2^WIDTH-1, include it in the count and go to DONE.
  - DONE: value_valid=1 and value held. value_ready=1 -> IDLE, or -> ACCUM (counters cleared) if start=1 in the same cycle. start without value_ready is ignored.
- Counting windows:
  - The sample on the start cycle is not counted; the first counted sample is the cycle after start.
  - sample_cnt wraps 2^WIDTH-1 -> 0 on the final sample.
- Latency: value_valid rises on the cycle after the 2^WIDTH-th valid sample. With continuous bit_valid this is 2^WIDTH+1 cycles after the start cycle.
- Unipolar arithmetic:
  - value = min(ones_cnt, 2^WIDTH-1).
  - An all-ones stream saturates to all-ones.
  - value is registered on entry to DONE.
- value keeps its last result in IDLE/ACCUM; only value_valid qualifies it.

Optional Feature:
- Macro: STOCH_DEC_BIPOLAR_EN.
- Defined: bipolar decode.
  - value = two's-complement of (ones_cnt - 2^(WIDTH-1)), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Examples: all-zeros -> 0x80; half ones -> 0x00; all ones -> 0x7F (saturated).
- Undefined: unipolar decode as above; no bipolar logic synthesised.
- Handshake and timing are identical in both modes.

Decomposition:
- Package stoch_pkg:
  - state enum typedef {IDLE, ACCUM, DONE};
  - default width constant STOCH_WIDTH=8, shared with the SNG/multiplier blocks.
- Sub-module stoch_window_counter:
  - sample_cnt plus ones_cnt, with clear/enable inputs;
  - outputs ones_cnt and a last_sample flag.
- The FSM, saturation and output registers stay in the top module.

Test Plan:
- Reset/defaults: assert rst mid-ACCUM (after 100 samples) -> busy, value_valid, value all 0 asynchronously. After release, new start + 256 ones -> 0xFF.
- Unipolar values (WIDTH=8, bit_valid=1 continuously):
  - 64 ones + 192 zeros -> value=0x40; value_valid on cycle 257 after start.
  - all zeros -> 0x00.
  - all ones -> 0xFF (saturated).
- Stalls: 256 samples with bit_valid toggling 1/0 and 128 counted ones -> value=0x80 after 512 cycles. Samples with bit_valid=0 and bit_in=1 are not counted.
- Handshake backpressure: hold value_ready=0 for 20 cycles in DONE -> value_valid and value stable; start pulses ignored. value_ready=1 -> IDLE next cycle.
- Back-to-back: start=1 and value_ready=1 in the same DONE cycle -> immediate ACCUM. Second window of 32 ones -> 0x20.
- Bipolar (STOCH_DEC_BIPOLAR_EN):
  - 128 ones -> 0x00; 0 ones -> 0x80; 256 ones -> 0x7F; 192 ones -> 0x40.
